// File: rtl/psk_tx_scheduler_pkg.sv
// ============================================================================
// psk_tx_scheduler_pkg : shared state encodings and widths for the PSK TX scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

package psk_tx_scheduler_pkg;

  localparam int SAMPLE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/psk_tx_scheduler_rr.sv
// ============================================================================
// rr_pick : combinational rotate-scan picker, priority starts at last+1
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] last,
  output logic                       valid,
  output logic [$clog2(NUM_SRC)-1:0] idx
);

  localparam int ID_W = $clog2(NUM_SRC);

  // Scan from farthest to nearest so the source closest to last+1 wins.
  always_comb begin
    valid = 1'b0;
    idx   = last;
    for (int k = NUM_SRC; k >= 1; k--) begin
      if (req[(int'(last) + k) % NUM_SRC]) begin
        valid = 1'b1;
        idx   = ID_W'((int'(last) + k) % NUM_SRC);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/psk_tx_scheduler.sv
// ============================================================================
// psk_tx_scheduler : round-robin burst scheduler sharing one PSK modulator
// Revision: 1.0
// ============================================================================
`default_nettype none

module psk_tx_scheduler
  import psk_tx_scheduler_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int BURST_LEN   = 16,
  parameter int GAP_CLKS    = 8,
  parameter int STARVE_CLKS = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         tx_en,
  input  logic [SAMPLE_W*NUM_SRC-1:0]  src_sample,
  input  logic [NUM_SRC-1:0]           src_empty,
  output logic [NUM_SRC-1:0]           src_read,
  output logic [SAMPLE_W-1:0]          mod_sample,
  output logic                         mod_empty,
  input  logic                         mod_read,
  output logic                         mod_enable,
  output logic [NUM_SRC-1:0]           grant,
  output logic [$clog2(NUM_SRC)-1:0]   src_id,
  output logic                         burst_done
);

  localparam int ID_W     = $clog2(NUM_SRC);
  localparam int BEAT_W   = $clog2(BURST_LEN + 1);
  localparam int STARVE_W = $clog2(STARVE_CLKS + 1);
  localparam int GAP_W    = $clog2(GAP_CLKS + 1);

  localparam logic [BEAT_W-1:0]   BEAT_LAST   = BEAT_W'(BURST_LEN - 1);
  localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_CLKS - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(GAP_CLKS - 1);

  state_e               state_q, state_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]      src_id_q, src_id_d;
  logic                 mod_enable_q, mod_enable_d;
  logic                 burst_done_q, burst_done_d;
  logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [STARVE_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;

  logic [NUM_SRC-1:0]   src_req;
  logic                 pick_valid;
  logic [ID_W-1:0]      pick_idx;
  logic                 cur_empty;
  logic                 in_burst;
  logic                 fwd_read;
  logic                 burst_end;

  assign src_req = ~src_empty;

  rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_pick (
    .req   (src_req),
    .last  (src_id_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // FIFO port mux: pass-through only while a burst owns the modulator.
  assign cur_empty  = src_empty[src_id_q];
  assign in_burst   = (state_q == ST_BURST) && !rst;
  assign fwd_read   = in_burst && mod_read && !cur_empty;
  assign mod_sample = src_sample[int'(src_id_q)*SAMPLE_W +: SAMPLE_W];
  assign mod_empty  = in_burst ? cur_empty : 1'b1;
  assign src_read   = fwd_read ? (NUM_SRC'(1) << src_id_q) : '0;

  assign burst_end  = (fwd_read && (beat_cnt_q == BEAT_LAST))
                   || (cur_empty && (starve_cnt_q == STARVE_LAST))
                   || !tx_en;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    src_id_d     = src_id_q;
    mod_enable_d = mod_enable_q;
    burst_done_d = 1'b0;
    beat_cnt_d   = beat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        mod_enable_d = 1'b0;
        if (tx_en && pick_valid) begin
          state_d      = ST_BURST;
          grant_d      = NUM_SRC'(1) << pick_idx;
          src_id_d     = pick_idx;
          beat_cnt_d   = '0;
          starve_cnt_d = '0;
          mod_enable_d = 1'b1;
        end
      end
      ST_BURST: begin
        if (fwd_read) begin
          beat_cnt_d   = beat_cnt_q + 1'b1;
          starve_cnt_d = '0;
        end else if (cur_empty) begin
          starve_cnt_d = starve_cnt_q + 1'b1;
        end else begin
          starve_cnt_d = '0;
        end
        if (burst_end) begin
          state_d      = ST_GAP;
          grant_d      = '0;
          burst_done_d = 1'b1;
          gap_cnt_d    = '0;
        end
      end
      ST_GAP: begin
        // Modulator stays enabled through the gap and holds its last sample.
        if (gap_cnt_q == GAP_LAST) begin
          state_d      = ST_IDLE;
          mod_enable_d = 1'b0;
          gap_cnt_d    = '0;
        end else begin
          gap_cnt_d    = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      src_id_q     <= ID_W'(NUM_SRC - 1);
      mod_enable_q <= 1'b0;
      burst_done_q <= 1'b0;
      beat_cnt_q   <= '0;
      starve_cnt_q <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      src_id_q     <= src_id_d;
      mod_enable_q <= mod_enable_d;
      burst_done_q <= burst_done_d;
      beat_cnt_q   <= beat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  assign grant      = grant_q;
  assign src_id     = src_id_q;
  assign mod_enable = mod_enable_q;
  assign burst_done = burst_done_q;

endmodule

`default_nettype wire

// File: tb/tb_psk_tx_scheduler.sv
// ============================================================================
// tb_psk_tx_scheduler : scoreboard bench for psk_tx_scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_psk_tx_scheduler;

  localparam int NUM_SRC     = 4;
  localparam int BURST_LEN   = 16;
  localparam int GAP_CLKS    = 8;
  localparam int STARVE_CLKS = 64;

  typedef struct {
    logic [3:0] grant;
    int         reads;
    int         erun;
    bit         by_reset;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   tx_en = 1'b0;
  logic                   mod_read = 1'b0;
  logic [8*NUM_SRC-1:0]   src_sample;
  logic [NUM_SRC-1:0]     src_empty;
  logic [NUM_SRC-1:0]     src_read;
  logic [NUM_SRC-1:0]     grant;
  logic [7:0]             mod_sample;
  logic                   mod_empty;
  logic                   mod_enable;
  logic                   burst_done;
  logic [1:0]             src_id;

  int   fill[NUM_SRC];
  int   consumed[NUM_SRC] = '{default: 0};
  int   n_checks = 0;
  int   n_err = 0;

  exp_t sb_q[$];
  exp_t cur;
  bit   active = 0;
  bit   in_gap = 0;
  int   reads, erun, gap_n, cidx;
  logic [3:0] exp_rd;
  logic       exp_me;

  always #5 clk = ~clk;

  psk_tx_scheduler #(
    .NUM_SRC     (NUM_SRC),
    .BURST_LEN   (BURST_LEN),
    .GAP_CLKS    (GAP_CLKS),
    .STARVE_CLKS (STARVE_CLKS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .src_sample (src_sample),
    .src_empty  (src_empty),
    .src_read   (src_read),
    .mod_sample (mod_sample),
    .mod_empty  (mod_empty),
    .mod_read   (mod_read),
    .mod_enable (mod_enable),
    .grant      (grant),
    .src_id     (src_id),
    .burst_done (burst_done)
  );

  function automatic logic [7:0] head_of(int i, int c);
    return 8'((i * 37 + c * 5 + 3) % 256);
  endfunction

  function automatic int idx_of(logic [3:0] g);
    for (int i = 0; i < NUM_SRC; i++) if (g[i]) return i;
    return 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Source FIFO environment: FWFT heads, consumed on src_read.
  always_comb begin
    src_empty  = '0;
    src_sample = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_empty[i]        = (fill[i] <= consumed[i]);
      src_sample[8*i +: 8] = head_of(i, consumed[i]);
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++)
      if (src_read[i]) consumed[i] <= consumed[i] + 1;
  end

  // Monitor: pops expected bursts when a grant appears and checks them when it ends.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_src_read", {28'd0, src_read}, 32'd0);
      chk("rst_mod_empty", {31'd0, mod_empty}, 32'd1);
      if (active) begin
        chk("burst_cut_by_reset", {31'd0, cur.by_reset}, 32'd1);
        chk("reset_burst_reads", reads, cur.reads);
        active = 0;
      end
      in_gap = 0;
    end else begin
      if (active && grant == 4'd0) begin
        chk("burst_ended_normally", {31'd0, cur.by_reset}, 32'd0);
        chk("burst_done", {31'd0, burst_done}, 32'd1);
        chk("burst_reads", reads, cur.reads);
        chk("starve_clks", erun, cur.erun);
        chk("gap_enable", {31'd0, mod_enable}, 32'd1);
        active = 0;
        in_gap = 1;
        gap_n  = 1;
      end else if (in_gap) begin
        if (mod_enable && grant == 4'd0) gap_n++;
        else begin
          chk("gap_clks", gap_n, GAP_CLKS);
          in_gap = 0;
        end
      end else if (burst_done) begin
        chk("stray_burst_done", {31'd0, burst_done}, 32'd0);
      end

      if (!active && !in_gap && grant != 4'd0) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_grant", {28'd0, grant}, 32'd0);
        end else begin
          cur = sb_q.pop_front();
          chk("grant", {28'd0, grant}, {28'd0, cur.grant});
          chk("src_id", {30'd0, src_id}, idx_of(cur.grant));
          chk("grant_enable", {31'd0, mod_enable}, 32'd1);
          active = 1;
          reads  = 0;
          erun   = 0;
        end
      end

      cidx   = idx_of(cur.grant);
      exp_me = active ? (fill[cidx] <= consumed[cidx]) : 1'b1;
      chk("mod_empty", {31'd0, mod_empty}, {31'd0, exp_me});
      exp_rd = (active && mod_read && !mod_empty) ? cur.grant : 4'd0;
      chk("src_read", {28'd0, src_read}, {28'd0, exp_rd});
      if (active && !mod_empty)
        chk("mod_sample", {24'd0, mod_sample}, {24'd0, head_of(cidx, consumed[cidx])});
      if (active) begin
        if (src_read != 4'd0) reads++;
        if (mod_empty) erun++;
        else erun = 0;
      end
    end
  end

  task automatic push(input logic [3:0] g, input int r, input int e, input bit br);
    exp_t x;
    x.grant = g; x.reads = r; x.erun = e; x.by_reset = br;
    sb_q.push_back(x);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge clk);
      #1;
      if (sb_q.size() == 0 && !active && !in_gap && grant == 4'd0 && !mod_enable) done = 1;
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_grant(input string name, input int budget);
    bit found;
    found = 0;
    for (int k = 0; k < budget && !found; k++) begin
      cyc(1);
      if (grant != 4'd0) found = 1;
    end
    chk(name, {31'd0, found}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < NUM_SRC; i++) fill[i] = 0;

    // 1: reset values
    cyc(2);
    chk("t1_grant", {28'd0, grant}, 32'd0);
    chk("t1_mod_enable", {31'd0, mod_enable}, 32'd0);
    chk("t1_mod_empty", {31'd0, mod_empty}, 32'd1);
    chk("t1_src_read", {28'd0, src_read}, 32'd0);
    chk("t1_src_id", {30'd0, src_id}, 32'd3);
    chk("t1_burst_done", {31'd0, burst_done}, 32'd0);
    rst = 1'b0;

    // 2: single source with 40 samples -> 16, 16, 8 (then 64 starve clocks)
    push(4'b0010, 16, 0, 0);
    push(4'b0010, 16, 0, 0);
    push(4'b0010, 8, STARVE_CLKS, 0);
    fill[1]  = consumed[1] + 40;
    tx_en    = 1'b1;
    mod_read = 1'b1;
    cyc(1);
    chk("t2_grant_latency", {28'd0, grant}, 32'b0010);
    wait_idle("t2_idle", 1000);

    // 3: round robin with every FIFO full
    rst = 1'b1;
    cyc(2);
    chk("t3_src_id_reset", {30'd0, src_id}, 32'd3);
    push(4'b0001, 16, 0, 0);
    push(4'b0010, 16, 0, 0);
    push(4'b0100, 16, 0, 0);
    push(4'b1000, 16, 0, 0);
    push(4'b0001, 16, 0, 0);
    fill[0] = consumed[0] + 32;
    for (int i = 1; i < NUM_SRC; i++) fill[i] = consumed[i] + 16;
    rst = 1'b0;
    wait_idle("t3_idle", 1000);

    // 4: starvation on src2, then src3 takes its turn
    push(4'b0100, 3, STARVE_CLKS, 0);
    push(4'b1000, 5, STARVE_CLKS, 0);
    fill[2] = consumed[2] + 3;
    fill[3] = consumed[3] + 5;
    wait_idle("t4_idle", 1000);

    // 5: tx_en drops in the clk of beat 5 while mod_read=1
    push(4'b0001, 6, 0, 0);
    fill[0] = consumed[0] + 20;
    wait_grant("t5_grant_seen", 50);
    cyc(5);
    tx_en = 1'b0;
    cyc(30);
    chk("t5_no_grant", {28'd0, grant}, 32'd0);
    chk("t5_enable_off", {31'd0, mod_enable}, 32'd0);
    chk("t5_src0_reads", consumed[0] - (fill[0] - 20), 32'd6);
    wait_idle("t5_idle", 200);

    // 6: reset at beat 7 with mod_read=1
    push(4'b0001, 7, 0, 1);
    tx_en = 1'b1;
    wait_grant("t6_grant_seen", 50);
    cyc(7);
    rst = 1'b1;
    #1;
    chk("t6_rst_src_read", {28'd0, src_read}, 32'd0);
    chk("t6_rst_mod_empty", {31'd0, mod_empty}, 32'd1);
    cyc(1);
    chk("t6_grant", {28'd0, grant}, 32'd0);
    chk("t6_mod_enable", {31'd0, mod_enable}, 32'd0);
    chk("t6_src_id", {30'd0, src_id}, 32'd3);
    chk("t6_burst_done", {31'd0, burst_done}, 32'd0);
    push(4'b0001, 7, STARVE_CLKS, 0);
    rst = 1'b0;
    wait_idle("t6_idle", 1000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
